maxpool22_relu: RTL

MAXPOOL22_RELU -- requirements
Module: maxpool22_relu

---
 rtl/lenet_pkg.sv | 29 ++
 rtl/sat_shift.sv | 46 ++++
 rtl/maxpool22_relu.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// ---------------------------------------------------------------------------
// Module : lenet_pkg
// Brief  : Shared LeNet constants (C3 map size, pooled size, datapath widths)
//          and the 2x2 pooling FSM state encoding.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package lenet_pkg;

   // Datapath widths of the conv -> pool boundary
   localparam int C_IN_WIDTH  = 32;
   localparam int C_OUT_WIDTH = 8;

   // C3 feature map (10x10) and its 2x2-pooled result (5x5)
   localparam int C_C3_MAP_W  = 10;
   localparam int C_C3_MAP_H  = 10;
   localparam int C_POOL_W    = C_C3_MAP_W / 2;
   localparam int C_POOL_H    = C_C3_MAP_H / 2;

   // Even rows store horizontal pair maxima, odd rows combine and emit
   typedef enum logic [0:0] {
      S_EVEN = 1'b0,
      S_ODD  = 1'b1
   } pool_state_t;

endpackage : lenet_pkg

`default_nettype wire

// File: rtl/sat_shift.sv
// ---------------------------------------------------------------------------
// Module : sat_shift
// Brief  : Combinational arithmetic right shift followed by saturation of a
//          signed IN_WIDTH value into a signed OUT_WIDTH value.
//          Macro MAXPOOL22_RELU_EN: lower saturation bound becomes 0.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sat_shift #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter int SHIFT     = 8
) (
   input  logic signed [IN_WIDTH-1:0]  i_data,
   output logic signed [OUT_WIDTH-1:0] o_data
);

   // Saturation bounds expressed at the full input width so the compare is
   // exact regardless of how far the shifted value is out of range.
   localparam logic signed [IN_WIDTH-1:0] C_MAX =
      {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
`ifdef MAXPOOL22_RELU_EN
   localparam logic signed [IN_WIDTH-1:0] C_MIN = '0;
`else
   localparam logic signed [IN_WIDTH-1:0] C_MIN =
      {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`endif

   logic signed [IN_WIDTH-1:0] w_shifted;

   assign w_shifted = i_data >>> SHIFT;

   // Clamp the shifted value into the representable output range
   always_comb begin
      o_data = w_shifted[OUT_WIDTH-1:0];
      if (w_shifted > C_MAX) begin
         o_data = C_MAX[OUT_WIDTH-1:0];
      end else if (w_shifted < C_MIN) begin
         o_data = C_MIN[OUT_WIDTH-1:0];
      end
   end

endmodule : sat_shift

`default_nettype wire

// File: rtl/maxpool22_relu.sv
// ---------------------------------------------------------------------------
// Module : maxpool22_relu
// Brief  : Streaming 2x2 max pooling (stride 2) with shift/saturate
//          requantization over a raster-ordered MAP_W x MAP_H map.
//          Macro MAXPOOL22_RELU_EN: negative inputs clamp to 0 (ReLU) and
//          the output range becomes [0, 2^(OUT_WIDTH-1)-1].
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module maxpool22_relu
   import lenet_pkg::*;
#(
   parameter int IN_WIDTH  = C_IN_WIDTH,
   parameter int OUT_WIDTH = C_OUT_WIDTH,
   parameter int MAP_W     = C_C3_MAP_W,
   parameter int MAP_H     = C_C3_MAP_H,
   parameter int SHIFT     = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clr,
   input  logic                        in_valid,
   input  logic signed [IN_WIDTH-1:0]  in_data,
   output logic                        out_valid,
   output logic signed [OUT_WIDTH-1:0] out_data,
   output logic                        frame_done
);

   localparam int C_COL_W     = $clog2(MAP_W);
   localparam int C_ROW_W     = $clog2(MAP_H);
   localparam int C_BUF_DEPTH = MAP_W / 2;

   pool_state_t r_state;
   pool_state_t w_state_next;

   logic        [C_COL_W-1:0]   r_col;
   logic        [C_ROW_W-1:0]   r_row;
   logic signed [IN_WIDTH-1:0]  r_pair;
   logic signed [IN_WIDTH-1:0]  r_rowbuf [C_BUF_DEPTH];
   logic                        r_out_valid;
   logic signed [OUT_WIDTH-1:0] r_out_data;
   logic                        r_frame_done;

   logic                        w_accept;
   logic                        w_col_last;
   logic                        w_row_last;
   logic                        w_col_odd;
   logic        [C_COL_W-2:0]   w_buf_idx;
   logic signed [IN_WIDTH-1:0]  w_pix;
   logic signed [IN_WIDTH-1:0]  w_pair_max;
   logic signed [IN_WIDTH-1:0]  w_buf_rd;
   logic signed [IN_WIDTH-1:0]  w_win_max;
   logic signed [OUT_WIDTH-1:0] w_sat;

   // clr wins over in_valid: an aborted sample never touches any state
   assign w_accept   = in_valid & ~clr;
   assign w_col_last = (r_col == C_COL_W'(MAP_W - 1));
   assign w_row_last = (r_row == C_ROW_W'(MAP_H - 1));
   assign w_col_odd  = r_col[0];
   assign w_buf_idx  = r_col[C_COL_W-1:1];

`ifdef MAXPOOL22_RELU_EN
   assign w_pix = in_data[IN_WIDTH-1] ? '0 : in_data;
`else
   assign w_pix = in_data;
`endif

   assign w_pair_max = (w_pix > r_pair) ? w_pix : r_pair;
   assign w_buf_rd   = r_rowbuf[w_buf_idx];
   assign w_win_max  = (w_pair_max > w_buf_rd) ? w_pair_max : w_buf_rd;

   sat_shift #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT)
   ) u_sat_shift (
      .i_data (w_win_max),
      .o_data (w_sat)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EVEN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state: row parity flips on the last pixel of every row
   always_comb begin
      w_state_next = r_state;
      if (clr) begin
         w_state_next = S_EVEN;
      end else if (in_valid && w_col_last) begin
         w_state_next = (r_state == S_EVEN) ? S_ODD : S_EVEN;
      end
   end

   // Raster position counters, advanced only by accepted pixels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (clr) begin
         r_col <= '0;
         r_row <= '0;
      end else if (in_valid) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // Left pixel of each horizontal pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pair <= '0;
      end else if (w_accept && !w_col_odd) begin
         r_pair <= w_pix;
      end
   end

   // Even-row pair maxima; always written before the odd row reads them
   always_ff @(posedge clk) begin
      if (w_accept && w_col_odd && (r_state == S_EVEN)) begin
         r_rowbuf[w_buf_idx] <= w_pair_max;
      end
   end

   // Registered pooled output; data holds between valid pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         if (w_accept && w_col_odd && (r_state == S_ODD)) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_sat;
            r_frame_done <= w_col_last & w_row_last;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign frame_done = r_frame_done;

endmodule : maxpool22_relu

`default_nettype wire
